sprite_ram_loader: RTL and testbench

- Writer end of the sprite pixel interface: accepts a byte stream (R,G,B per pixel, raster order) over a valid/ready handshake and fills an on-chip sprite RAM.
- Exposes the same SpriteX/SpriteY → SpriteR/G/B lookup the color mapper already uses, with registered output.
- Lets sprite art be replaced at runtime from a host link instead of being baked into a ROM.
- Sits between the host byte receiver and the color mapper.

---
 rtl/sprite_ram_loader.sv | 133 +++++++++++++
 tb/tb_sprite_ram_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_ram_loader.sv
// Streams R,G,B bytes into a sprite RAM and serves registered X/Y pixel lookups.
// state  | meaning
// IDLE   | no load since reset
// LOAD_R | waiting for red byte of pixel addr
// LOAD_G | waiting for green byte
// LOAD_B | waiting for blue byte, writes the pixel
// DONE   | last load completed, holding until Start
module sprite_ram_loader #(
   parameter int SPRITE_W = 8,
   parameter int SPRITE_H = 8,
   parameter int DEPTH    = SPRITE_W * SPRITE_H,
   parameter int ADDR_W   = $clog2(DEPTH)
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              Start,
   input  logic [7:0]        Byte_In,
   input  logic              Byte_Valid,
   output logic              Byte_Ready,
   output logic              Busy,
   output logic              Load_Done,
   output logic [ADDR_W:0]   Pixel_Count,
   input  logic [9:0]        SpriteX,
   input  logic [9:0]        SpriteY,
   output logic [7:0]        SpriteR,
   output logic [7:0]        SpriteG,
   output logic [7:0]        SpriteB
);

   localparam int X_W = $clog2(SPRITE_W);
   localparam int Y_W = $clog2(SPRITE_H);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [2:0] {IDLE, LOAD_R, LOAD_G, LOAD_B, DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     cnt_q, cnt_d;
   logic [7:0]          r_q, r_d;
   logic [7:0]          g_q, g_d;
   logic                done_q, done_d;
   logic                loading;
   logic                xfer;
   logic                we;
   logic [23:0]         wdata;
   logic [ADDR_W-1:0]   rd_idx;
   logic [23:0]         pix_q;
   logic [23:0]         mem [DEPTH];
   logic                unused_hi;

   assign loading = (state_q == LOAD_R) || (state_q == LOAD_G) || (state_q == LOAD_B);
   assign xfer    = Byte_Valid && loading;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      g_d     = g_q;
      done_d  = 1'b0;
      we      = 1'b0;
      wdata   = {r_q, g_q, Byte_In};
      // Start wins over any byte on the same edge, including a restart mid-load.
      if (Start) begin
         state_d = LOAD_R;
         addr_d  = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            LOAD_R: if (xfer) begin
               r_d     = Byte_In;
               state_d = LOAD_G;
            end
            LOAD_G: if (xfer) begin
               g_d     = Byte_In;
               state_d = LOAD_B;
            end
            LOAD_B: if (xfer) begin
               we    = 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (addr_q == LAST_ADDR) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  addr_d  = addr_q + 1'b1;
                  state_d = LOAD_R;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         r_q     <= '0;
         g_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         g_q     <= g_d;
         done_q  <= done_d;
      end
   end

   // RAM kept free of reset so it maps onto block RAM; read-before-write on collision.
   always_ff @(posedge Clk) begin
      if (we) mem[addr_q] <= wdata;
   end

   assign rd_idx    = {SpriteY[Y_W-1:0], SpriteX[X_W-1:0]};
   assign unused_hi = ^{SpriteX[9:X_W], SpriteY[9:Y_W]};

   always_ff @(posedge Clk) begin
      if (!Reset_n) pix_q <= '0;
      else          pix_q <= mem[rd_idx];
   end

   assign Byte_Ready  = loading;
   assign Busy        = loading;
   assign Load_Done   = done_q;
   assign Pixel_Count = cnt_q;
   assign SpriteR     = pix_q[23:16];
   assign SpriteG     = pix_q[15:8];
   assign SpriteB     = pix_q[7:0];

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Scoreboard bench for sprite_ram_loader: a byte-index reference model feeds queues
// that a negedge monitor drains against the DUT outputs.
module tb_sprite_ram_loader;

   localparam int SW    = 8;
   localparam int SH    = 8;
   localparam int NPIX  = SW * SH;
   localparam int NBYTE = NPIX * 3;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       Start = 1'b0;
   logic [7:0] Byte_In = '0;
   logic       Byte_Valid = 1'b0;
   logic       Byte_Ready;
   logic       Busy;
   logic       Load_Done;
   logic [6:0] Pixel_Count;
   logic [9:0] SpriteX = '0;
   logic [9:0] SpriteY = '0;
   logic [7:0] SpriteR, SpriteG, SpriteB;

   sprite_ram_loader dut (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Byte_In(Byte_In),
      .Byte_Valid(Byte_Valid), .Byte_Ready(Byte_Ready), .Busy(Busy),
      .Load_Done(Load_Done), .Pixel_Count(Pixel_Count),
      .SpriteX(SpriteX), .SpriteY(SpriteY),
      .SpriteR(SpriteR), .SpriteG(SpriteG), .SpriteB(SpriteB)
   );

   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [23:0] d;
      bit          chk;
   } rd_t;

   logic [23:0] ref_mem [NPIX];
   bit          ref_ok  [NPIX];
   rd_t         rd_q [$];
   int          done_q [$];
   int          cyc = 0;
   int          m_k = 0;
   int          m_cnt = 0;
   bit          m_load = 0;
   bit          m_live = 0;
   logic [7:0]  m_r, m_g;
   bit          rd_rand = 1;

   initial for (int i = 0; i < NPIX; i++) ref_ok[i] = 0;

   // Reference model: a load is just "byte number k of 192"; pixel k/3, channel k%3.
   always @(posedge Clk) begin
      int idx;
      rd_t e;
      cyc++;
      idx = (int'(SpriteY) % SH) * SW + (int'(SpriteX) % SW);
      if (!Reset_n) begin
         e.d = '0; e.chk = 1;
         rd_q.push_back(e);
         m_load = 0;
         m_cnt  = 0;
      end else begin
         e.d = ref_mem[idx]; e.chk = ref_ok[idx];
         rd_q.push_back(e);
         if (Start) begin
            m_load = 1;
            m_k    = 0;
            m_cnt  = 0;
         end else if (m_load && Byte_Valid) begin
            if (m_k % 3 == 0)      m_r = Byte_In;
            else if (m_k % 3 == 1) m_g = Byte_In;
            else begin
               ref_mem[m_k / 3] = {m_r, m_g, Byte_In};
               ref_ok[m_k / 3]  = 1;
               m_cnt++;
            end
            m_k++;
            if (m_k == NBYTE) begin
               m_load = 0;
               done_q.push_back(cyc);
            end
         end
      end
      m_live = 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   always @(negedge Clk) begin
      bit  exp_done;
      rd_t r;
      if (m_live) begin
         chk("busy", 32'(Busy), 32'(m_load));
         chk("byte_ready", 32'(Byte_Ready), 32'(m_load));
         chk("pixel_count", 32'(Pixel_Count), 32'(m_cnt));
         exp_done = (done_q.size() > 0) && (done_q[0] == cyc);
         if (exp_done) void'(done_q.pop_front());
         chk("load_done", 32'(Load_Done), 32'(exp_done));
         if (rd_q.size() > 0) begin
            r = rd_q.pop_front();
            if (r.chk) chk("sprite_rgb", 32'({SpriteR, SpriteG, SpriteB}), 32'(r.d));
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
      if (rd_rand) begin
         SpriteX = 10'($urandom);
         SpriteY = 10'($urandom);
      end
   endtask

   task automatic pulse_start(input bit with_byte);
      Start      = 1'b1;
      Byte_Valid = with_byte;
      Byte_In    = 8'h55;
      tick();
      Start      = 1'b0;
      Byte_Valid = 1'b0;
   endtask

   // mode: 0 valid held, 1 valid toggling, 2 random valid; pat: 0 counting, 1 0xAA, 2 random
   task automatic send(input int n, input int mode, input int pat);
      int i = 0;
      int guard = 0;
      bit v;
      while (i < n && guard < 4000) begin
         case (mode)
            0:       v = 1;
            1:       v = (guard % 2 == 0);
            default: v = bit'($urandom_range(0, 1));
         endcase
         Byte_Valid = v;
         if (!v)            Byte_In = 8'($urandom);
         else if (pat == 0) Byte_In = i[7:0];
         else if (pat == 1) Byte_In = 8'hAA;
         else               Byte_In = 8'($urandom);
         @(negedge Clk);
         if (Byte_Valid && Byte_Ready) i++;
         tick();
         guard++;
      end
      Byte_Valid = 1'b0;
      chk("send_complete", 32'(i), 32'(n));
   endtask

   task automatic sweep();
      rd_rand = 0;
      for (int p = 0; p < NPIX; p++) begin
         SpriteX = 10'((p % SW) + SW * $urandom_range(0, 127));
         SpriteY = 10'((p / SW) + SH * $urandom_range(0, 127));
         tick();
      end
      tick();
      rd_rand = 1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      Reset_n = 1'b0;
      idle(3);
      Reset_n = 1'b1;
      idle(3);

      // counting load, valid held
      pulse_start(0);
      send(NBYTE, 0, 0);
      idle(4);
      rd_rand = 0;
      SpriteX = 10'd3; SpriteY = 10'd2;
      idle(2);
      rd_rand = 1;
      sweep();

      // same load, valid toggling
      pulse_start(0);
      send(NBYTE, 1, 0);
      idle(3);
      sweep();

      // restart after 10 bytes, byte on the Start edge must be dropped
      pulse_start(0);
      send(10, 0, 2);
      pulse_start(1);
      send(NBYTE, 0, 1);
      idle(3);
      sweep();
      rd_rand = 0;
      SpriteX = 10'd11; SpriteY = 10'd9;
      idle(2);
      SpriteX = 10'd3; SpriteY = 10'd1;
      idle(2);

      // random load while reading aliased pixel 1 throughout (read-during-write)
      SpriteX = 10'd9; SpriteY = 10'd8;
      pulse_start(0);
      send(NBYTE, 2, 2);
      idle(3);
      rd_rand = 1;
      sweep();

      // Start issued from DONE with random traffic
      pulse_start(0);
      send(NBYTE, 2, 2);
      idle(2);

      // reset mid-load, then bytes offered without Start are ignored
      pulse_start(0);
      send(50, 0, 2);
      Reset_n = 1'b0;
      tick();
      Reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         Byte_Valid = 1'b1;
         Byte_In    = 8'($urandom);
         tick();
      end
      Byte_Valid = 1'b0;
      sweep();
      idle(3);

      chk("done_queue_drained", 32'(done_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
